// File: rtl/fpa_operand_stage.sv
// Operand front-end for the single-precision FP adder: classifies specials, flushes subnormals,
// and buffers pairs in a main+skid slot pair. Optional counters under FPA_OPSTAGE_PERF_EN.
module fpa_operand_stage #(
  parameter logic [31:0] QNAN   = 32'h7FC0_0000,
  parameter int          PERF_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic        out_bypass,
  output logic [31:0] out_bypass_val,
  output logic [3:0]  out_flags
`ifdef FPA_OPSTAGE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_ops,
  output logic [PERF_W-1:0] perf_byp
`endif
);

  localparam logic [31:0] PINF   = 32'h7F80_0000;
  localparam int          SLOT_W = 32 + 32 + 1 + 32 + 4;

  // Slot layout: {a, b, bypass, bypass_val, flags}
  localparam int FLG_LSB = 0;
  localparam int VAL_LSB = 4;
  localparam int BYP_BIT = 36;
  localparam int B_LSB   = 37;
  localparam int A_LSB   = 69;

  function automatic logic [31:0] ftz(input logic [31:0] x);
    return (x[30:23] == 8'h00) ? {x[31], 31'h0} : x;
  endfunction

  logic              a_emax, a_emin, a_fnz, b_emax, b_emin, b_fnz;
  logic              a_nan, a_inf, a_sub, b_nan, b_inf, b_sub;
  logic              any_nan, any_inf, a_zero, b_zero;
  logic [31:0]       a_ftz, b_ftz;
  logic              byp;
  logic [31:0]       byp_val;
  logic [3:0]        flags;
  logic [SLOT_W-1:0] in_slot;

  assign a_emax = &in_a[30:23];
  assign a_emin = ~|in_a[30:23];
  assign a_fnz  = |in_a[22:0];
  assign b_emax = &in_b[30:23];
  assign b_emin = ~|in_b[30:23];
  assign b_fnz  = |in_b[22:0];

  assign a_nan  = a_emax & a_fnz;
  assign a_inf  = a_emax & ~a_fnz;
  assign a_sub  = a_emin & a_fnz;
  assign b_nan  = b_emax & b_fnz;
  assign b_inf  = b_emax & ~b_fnz;
  assign b_sub  = b_emin & b_fnz;

  // A subnormal becomes zero after FTZ, so a zero exponent alone means zero.
  assign a_zero  = a_emin;
  assign b_zero  = b_emin;
  assign any_nan = a_nan | b_nan;
  assign any_inf = a_inf | b_inf;
  assign a_ftz   = ftz(in_a);
  assign b_ftz   = ftz(in_b);

  always_comb begin
    byp     = 1'b1;
    byp_val = 32'h0;
    casez ({any_nan, any_inf, a_zero & b_zero, a_zero, b_zero})
      5'b1????: byp_val = QNAN;
      5'b01???: byp_val = PINF;
      5'b001??: byp_val = 32'h0;
      5'b0001?: byp_val = {1'b0, b_ftz[30:0]};
      5'b00001: byp_val = {1'b0, a_ftz[30:0]};
      default: begin
        byp     = 1'b0;
        byp_val = 32'h0;
      end
    endcase
  end

  assign flags   = {any_nan, any_inf & ~any_nan, a_zero | b_zero, a_sub | b_sub};
  assign in_slot = {a_ftz, b_ftz, byp, byp_val, flags};

  // ---- slot registers: main drives the adder, skid absorbs one pair under stall ----
  logic              main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [SLOT_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              accept, issue;

  assign in_ready = ~skid_vld_q;
  assign accept   = in_valid & in_ready;
  assign issue    = main_vld_q & out_ready;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_ready) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_slot;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_d     = in_slot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign out_valid      = main_vld_q;
  assign out_a          = main_q[A_LSB +: 32];
  assign out_b          = main_q[B_LSB +: 32];
  assign out_bypass     = main_q[BYP_BIT];
  assign out_bypass_val = main_q[VAL_LSB +: 32];
  assign out_flags      = main_q[FLG_LSB +: 4];

`ifdef FPA_OPSTAGE_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  // ---- performance counters: survive flush, cleared only by reset ----
  logic [PERF_W-1:0] perf_ops_q, perf_byp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ops_q <= '0;
      perf_byp_q <= '0;
    end else begin
      if (issue) perf_ops_q <= sat_inc(perf_ops_q);
      if (issue && out_bypass) perf_byp_q <= sat_inc(perf_byp_q);
    end
  end

  assign perf_ops = perf_ops_q;
  assign perf_byp = perf_byp_q;
`else
  if (PERF_W < 1) begin : g_perf_w_check
  end
  logic unused_issue;
  assign unused_issue = issue;
`endif

endmodule

// File: doc/fpa_operand_stage.md
Name: fpa_operand_stage

Overview:
Registered operand front-end placed directly upstream of the single-precision floating-point adder. Accepts operand pairs over a valid/ready handshake and classifies IEEE-754 special values. Flushes subnormals to zero and computes a bypass result whenever the adder's normal-magnitude datapath must not be used. Presents one registered operand pair per cycle to the adder, with a 2-entry skid buffer for full throughput under backpressure.

Parameters:
QNAN, 32'h7FC0_0000, canonical quiet-NaN bypass value
PERF_W, 16, width of performance counters (used only with the optional feature)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of all buffered operands
in_valid  input  1  upstream operand pair valid
in_ready  output  1  stage can accept; equals NOT skid_valid
in_a  input  32  operand A, IEEE-754 single
in_b  input  32  operand B, IEEE-754 single
out_valid  output  1  registered pair valid toward adder
out_ready  input  1  adder/consumer accepts
out_a  output  32  operand A after FTZ, sign preserved
out_b  output  32  operand B after FTZ, sign preserved
out_bypass  output  1  consumer must use out_bypass_val instead of adder sum
out_bypass_val  output  32  special-case result
out_flags  output  4  {nan, inf, zero, ftz}; ftz = at least one operand was subnormal

Behaviour:
- Storage: main slot (drives outputs) plus skid slot. Each slot holds {a, b, bypass, bypass_val, flags}.
- Transfers: accept = in_valid & in_ready; issue = out_valid & out_ready.
- Latency: a pair accepted at edge N appears on the outputs after edge N. There is no combinational path from in_* to out_*.
- Slot update rules:
  - Main empty or issuing: main loads skid if skid is valid, otherwise main loads input on accept.
  - Main full and stalled (out_valid & !out_ready): an accept goes to skid.
  - in_ready is low whenever skid is full.
- Ordering is strictly FIFO. Throughput is 1 pair/cycle while out_ready=1.
- Classification uses e = x[30:23] and f = x[22:0]:
  - NaN: e=FF, f!=0
  - Inf: e=FF, f=0
  - zero: e=0, f=0
  - subnormal: e=0, f!=0; flushed to sign-preserved zero and sets ftz
- Bypass priority, first match wins:
  1. Any NaN -> QNAN.
  2. Any Inf -> 32'h7F80_0000.
  3. Both zero after FTZ -> 32'h0000_0000.
  4. A zero -> {1'b0, b[30:0]}.
  5. B zero -> {1'b0, a[30:0]}.
  6. Otherwise out_bypass=0 and out_bypass_val=0.
- flags[1] (inf) is set only when no NaN is present. flags[2] (zero) is set when either operand is zero after FTZ.
- flush: both slots are invalidated at the next edge. Flush has priority over an accept in the same cycle, so that input is dropped. An issue in the flush cycle still counts as consumed.
- Reset values: out_valid=0; main and skid invalid; all data outputs 0; in_ready=1 during and after reset.
- Reset asserted mid-stream discards both slots immediately, without waiting for a clock edge.
- Data outputs hold their value while out_valid=1 and out_ready=0. They are don't-care-stable (held) when out_valid=0.

Optional Feature:
FPA_OPSTAGE_PERF_EN
- Defined:
  - Adds outputs perf_ops[PERF_W-1:0] (incremented on each issue) and perf_byp[PERF_W-1:0] (incremented on each issue with out_bypass=1).
  - Counters saturate at all-ones, reset to 0, and are not cleared by flush.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Normal pair: in_a=3F80_0000, in_b=4000_0000, out_ready=1 -> next cycle out_valid=1, out_a=3F80_0000, out_b=4000_0000, out_bypass=0, flags=0000.
- Specials:
  - a=7FC0_0001, b=7F80_0000 -> bypass=1, val=7FC0_0000, flags=1000.
  - a=7F80_0000, b=3F80_0000 -> val=7F80_0000, flags=0100.
- FTZ: a=0000_0001, b=4040_0000 -> out_a=0000_0000, bypass=1, val=4040_0000, flags=0011.
- Backpressure:
  - Stream 4 pairs P0..P3 with out_ready=0 from cycle 1 -> P0 in main, P1 in skid, in_ready=0, P2 held upstream.
  - Raise out_ready -> P0..P3 emerge in order, one per cycle, none lost or duplicated.
- Flush: main+skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle input never appears.
- Async reset mid-stream: reset pulse between edges -> out_valid drops to 0 immediately. With FPA_OPSTAGE_PERF_EN, perf_ops reads 0 afterwards.
